unidade_busca: RTL and testbench

Program-counter and fetch-control stage directly upstream of the instruction memory. Holds the current instruction address, drives the memory's 8-bit `Endereco` input, and computes the next address from sequential, relative-branch, absolute-jump, call/return and halt/stall controls. Memory samples `Endereco` on the falling edge. This block therefore updates on the rising edge, and the instruction for the current address is stable by the next rising edge.

---
 rtl/unidade_busca.sv | 123 ++++++++++++
 tb/tb_unidade_busca.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/unidade_busca.sv
// Program counter and fetch control ahead of the instruction memory: sequential advance,
// relative branch, absolute jump, call/return through a small stack, and halt/stall.
module unidade_busca #(
  parameter int unsigned LARGURA     = 8,
  parameter int unsigned PROF_PILHA  = 4,
  parameter int unsigned END_INICIAL = 0
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Stall,
  input  logic               Halt,
  input  logic               Retomar,
  input  logic               Desvio,
  input  logic               Salto,
  input  logic               Chamada,
  input  logic               Retorno,
  input  logic [LARGURA-1:0] Deslocamento,
  input  logic [LARGURA-1:0] Alvo,
  output logic [LARGURA-1:0] Endereco,
  output logic [LARGURA-1:0] PcMais1,
  output logic               Valido,
  output logic               Parado,
  output logic               ErroPilha
);

  localparam int unsigned LarguraCont = $clog2(PROF_PILHA + 1);
  localparam int unsigned LarguraIdx  = (PROF_PILHA > 1) ? $clog2(PROF_PILHA) : 1;

  typedef enum logic [0:0] {StExec, StParado} estado_e;

  estado_e                estado_q, estado_d;
  logic [LARGURA-1:0]     pc_q, pc_d;
  logic [LarguraCont-1:0] cont_q, cont_d;
  logic                   erro_q, erro_d;
  logic [LARGURA-1:0]     pilha_q [PROF_PILHA];

  logic                  empilha;
  logic [LarguraIdx-1:0] idx_push;
  logic [LarguraIdx-1:0] idx_topo;
  logic                  pilha_cheia;
  logic                  pilha_vazia;

  // Count never exceeds PROF_PILHA, so its low bits address the next free entry.
  assign idx_push    = cont_q[LarguraIdx-1:0];
  assign idx_topo    = LarguraIdx'(cont_q - LarguraCont'(1));
  assign pilha_cheia = (cont_q == LarguraCont'(PROF_PILHA));
  assign pilha_vazia = (cont_q == '0);

  assign PcMais1   = pc_q + LARGURA'(1);
  assign Endereco  = pc_q;
  assign Parado    = (estado_q == StParado);
  assign ErroPilha = erro_q;
  assign Valido    = (estado_q == StExec) && !Stall;

  always_comb begin
    estado_d = estado_q;
    pc_d     = pc_q;
    cont_d   = cont_q;
    erro_d   = erro_q;
    empilha  = 1'b0;
    unique case (estado_q)
      StExec: begin
        if (Halt) begin
          estado_d = StParado;
        end else if (!Stall) begin
          if (Retorno) begin
            if (pilha_vazia) begin
              erro_d = 1'b1;
              pc_d   = PcMais1;
            end else begin
              pc_d   = pilha_q[idx_topo];
              cont_d = cont_q - LarguraCont'(1);
            end
          end else if (Chamada) begin
            // Overflowing call still jumps; only the return address is lost.
            pc_d = Alvo;
            if (pilha_cheia) begin
              erro_d = 1'b1;
            end else begin
              empilha = 1'b1;
              cont_d  = cont_q + LarguraCont'(1);
            end
          end else if (Salto) begin
            pc_d = Alvo;
          end else if (Desvio) begin
            pc_d = pc_q + Deslocamento;
          end else begin
            pc_d = PcMais1;
          end
        end
      end
      StParado: begin
        if (Retomar) begin
          estado_d = StExec;
          pc_d     = PcMais1;
        end
      end
      default: estado_d = StExec;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      estado_q <= StExec;
      pc_q     <= LARGURA'(END_INICIAL);
      cont_q   <= '0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      pc_q     <= pc_d;
      cont_q   <= cont_d;
      erro_q   <= erro_d;
    end
  end

  // Stack contents need no reset; the count alone defines which entries are live.
  always_ff @(posedge Clock) begin
    if (empilha) begin
      pilha_q[idx_push] <= PcMais1;
    end
  end

endmodule

// File: tb/tb_unidade_busca.sv
// Directed bench for unidade_busca: stimulus pushes the hand-computed state expected in each
// cycle into a queue; a monitor pops and compares on every falling edge.
module tb_unidade_busca;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall, halt, retomar, desvio, salto, chamada, retorno;
  logic [7:0] desl, alvo;
  logic [7:0] endereco, pc_mais1;
  logic       valido, parado, erro_pilha;

  typedef struct packed {
    int         passo;
    logic [7:0] pc;
    logic [7:0] pc1;
    logic       val;
    logic       par;
    logic       err;
  } esperado_t;

  esperado_t fila [$];
  int checks = 0;
  int errors = 0;
  int passo  = 0;

  unidade_busca #(
    .LARGURA    (8),
    .PROF_PILHA (4),
    .END_INICIAL(0)
  ) dut (
    .Clock       (clk),
    .Reset       (rst),
    .Stall       (stall),
    .Halt        (halt),
    .Retomar     (retomar),
    .Desvio      (desvio),
    .Salto       (salto),
    .Chamada     (chamada),
    .Retorno     (retorno),
    .Deslocamento(desl),
    .Alvo        (alvo),
    .Endereco    (endereco),
    .PcMais1     (pc_mais1),
    .Valido      (valido),
    .Parado      (parado),
    .ErroPilha   (erro_pilha)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are stable mid-cycle; inputs change only just after the rising edge.
  always @(negedge clk) begin
    if (fila.size() > 0) begin
      esperado_t e;
      e = fila.pop_front();
      checks++;
      if ({endereco, pc_mais1, valido, parado, erro_pilha} !== {e.pc, e.pc1, e.val, e.par, e.err})
      begin
        errors++;
        $display("FAIL passo %0d: got pc=%0d pc1=%0d val=%b par=%b err=%b, expected pc=%0d pc1=%0d val=%b par=%b err=%b",
                 e.passo, endereco, pc_mais1, valido, parado, erro_pilha,
                 e.pc, e.pc1, e.val, e.par, e.err);
      end
    end
  end

  task automatic limpa();
    stall = 0; halt = 0; retomar = 0; desvio = 0; salto = 0; chamada = 0; retorno = 0;
    desl = 8'd0; alvo = 8'd0; rst = 1'b1;
  endtask

  // Expected state in the cycle the current inputs are applied; then take one edge.
  task automatic tick(input logic [7:0] e_pc, input logic e_val, input logic e_par,
                      input logic e_err);
    esperado_t e;
    logic [7:0] p1;
    p1 = e_pc + 8'd1;
    e.passo = passo;
    e.pc = e_pc;
    e.pc1 = p1;
    e.val = e_val;
    e.par = e_par;
    e.err = e_err;
    fila.push_back(e);
    passo++;
    @(posedge clk);
    #1;
    limpa();
  endtask

  initial begin
    limpa();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Sequential fetch with wrap 255 -> 0
    for (int i = 0; i < 260; i++) begin
      tick(8'(i % 256), 1, 0, 0);
    end
    // Branch wrap both directions
    salto = 1; alvo = 8'd250;        tick(8'd4, 1, 0, 0);
    desvio = 1; desl = 8'd10;        tick(8'd250, 1, 0, 0);
    salto = 1; alvo = 8'd3;          tick(8'd4, 1, 0, 0);
    desvio = 1; desl = 8'hFB;        tick(8'd3, 1, 0, 0);
    tick(8'd254, 1, 0, 0);
    salto = 1; alvo = 8'd10;         tick(8'd255, 1, 0, 0);
    // Nested calls and returns
    chamada = 1; alvo = 8'd20;       tick(8'd10, 1, 0, 0);
    chamada = 1; alvo = 8'd30;       tick(8'd20, 1, 0, 0);
    chamada = 1; alvo = 8'd40;       tick(8'd30, 1, 0, 0);
    chamada = 1; alvo = 8'd50;       tick(8'd40, 1, 0, 0);
    retorno = 1;                     tick(8'd50, 1, 0, 0);
    retorno = 1;                     tick(8'd41, 1, 0, 0);
    retorno = 1;                     tick(8'd31, 1, 0, 0);
    retorno = 1;                     tick(8'd21, 1, 0, 0);
    // Fill the stack, then overflow
    chamada = 1; alvo = 8'd60;       tick(8'd11, 1, 0, 0);
    chamada = 1; alvo = 8'd70;       tick(8'd60, 1, 0, 0);
    chamada = 1; alvo = 8'd80;       tick(8'd70, 1, 0, 0);
    chamada = 1; alvo = 8'd90;       tick(8'd80, 1, 0, 0);
    chamada = 1; alvo = 8'd100;      tick(8'd90, 1, 0, 0);
    retorno = 1;                     tick(8'd100, 1, 0, 1);
    // Reset clears the error flag and the stack
    rst = 0;                         tick(8'd81, 1, 0, 1);
    salto = 1; alvo = 8'd7;          tick(8'd0, 1, 0, 0);
    retorno = 1;                     tick(8'd7, 1, 0, 0);
    tick(8'd8, 1, 0, 1);
    // Call plus return together: pop only, so the next return underflows
    chamada = 1; alvo = 8'd30;       tick(8'd9, 1, 0, 1);
    retorno = 1; chamada = 1; alvo = 8'd99; tick(8'd30, 1, 0, 1);
    retorno = 1;                     tick(8'd10, 1, 0, 1);
    // Halt beats jump; everything but resume ignored while halted
    halt = 1; salto = 1; alvo = 8'd200; tick(8'd11, 1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      salto = 1; alvo = 8'd200; retorno = 1; desvio = 1; desl = 8'd5;
      tick(8'd11, 0, 1, 1);
    end
    retomar = 1;                     tick(8'd11, 0, 1, 1);
    // Stall beats jump
    stall = 1; salto = 1; alvo = 8'd77; tick(8'd12, 0, 0, 1);
    tick(8'd12, 1, 0, 1);
    // Halt beats stall, then reset while halted
    halt = 1; stall = 1;             tick(8'd13, 0, 0, 1);
    rst = 0; retomar = 1;            tick(8'd13, 0, 1, 1);
    tick(8'd0, 1, 0, 0);
    tick(8'd1, 1, 0, 0);

    @(negedge clk);
    #1;
    checks++;
    if (fila.size() != 0) begin
      errors++;
      $display("FAIL fila_vazia: got %0d pending, expected 0", fila.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
